// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative signed/unsigned multiply/divide unit producing HI/LO
// Shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o,
    output logic             stallreq_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               negp_q, negp_d, negr_q, negr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               accept, div_zero, sa, sb, sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff, rem_nx;
    logic [2*WIDTH-1:0] acc_nx, prod_fin;
    logic [WIDTH-1:0]   quo_nx, quo_fin, rem_fin;

    assign accept   = (state_q == S_IDLE) && start_i && !annul_i;
    assign div_zero = op_i[1] && (opb_i == '0);
    assign sa       = !op_i[0] && opa_i[WIDTH-1];
    assign sb       = !op_i[0] && opb_i[WIDTH-1];
    assign mag_a    = sa ? -opa_i : opa_i;
    assign mag_b    = sb ? -opb_i : opb_i;
    assign sgn      = !op_q[0];

    // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign acc_nx   = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fin = (sgn && negp_q) ? -acc_nx : acc_nx;

    // Divide: a_q shifts the dividend out at the top and the quotient in at the bottom.
    assign div_sh   = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign rem_nx   = div_diff[WIDTH] ? div_sh : div_diff;
    assign quo_nx   = {a_q[WIDTH-2:0], !div_diff[WIDTH]};
    assign quo_fin  = (sgn && negp_q) ? -quo_nx : quo_nx;
    assign rem_fin  = (sgn && negr_q) ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = div_zero ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (annul_i)            state_d = S_IDLE;
                else if (cnt_q == LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q == S_BUSY);
        ready_o       = (state_q == S_DONE);
        div_by_zero_o = (state_q == S_DONE) && dbz_q;
        stallreq_o    = accept || (state_q == S_BUSY);
        hi_o          = hi_q;
        lo_o          = lo_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        negp_d = negp_q;
        negr_d = negr_q;
        acc_d  = acc_q;
        rem_d  = rem_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dbz_d  = dbz_q;
        if (accept) begin
            cnt_d  = '0;
            op_d   = op_i;
            a_d    = mag_a;
            b_d    = mag_b;
            negp_d = sa ^ sb;
            negr_d = sa;
            acc_d  = '0;
            rem_d  = '0;
            if (div_zero) begin
                hi_d  = opa_i;
                lo_d  = '1;
                dbz_d = 1'b1;
            end
        end else if (state_q == S_BUSY && !annul_i) begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[1]) begin
                rem_d = rem_nx;
                a_d   = quo_nx;
            end else begin
                acc_d = acc_nx;
                b_d   = b_q >> 1;
            end
            if (cnt_q == LAST) begin
                dbz_d = 1'b0;
                if (op_q[1]) begin
                    hi_d = rem_fin;
                    lo_d = quo_fin;
                end else begin
                    hi_d = prod_fin[2*WIDTH-1:WIDTH];
                    lo_d = prod_fin[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            negp_q <= 1'b0;
            negr_q <= 1'b0;
            acc_q  <= '0;
            rem_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            negp_q <= negp_d;
            negr_q <= negr_d;
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dbz_q  <= dbz_d;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed and random scoreboard bench for md_unit
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst, start_i, annul_i;
    logic [1:0]  op_i;
    logic [31:0] opa_i, opb_i, hi_o, lo_o;
    logic        busy_o, ready_o, div_by_zero_o, stallreq_o;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
        .annul_i(annul_i), .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o),
        .div_by_zero_o(div_by_zero_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        case (op)
            2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = '1; e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Drive an op in the cycle after the current one; wait for ready and check against the scoreboard.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int exp_lat, input bit hold);
        int   n;
        bit   got, seen_busy, stall_bad, dbz_bad;
        exp_t x;
        @(posedge clk); #1;
        op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        chk("stall_accept", stallreq_o, 1'b1);
        n = 0; got = 0; seen_busy = 0; stall_bad = 0; dbz_bad = 0;
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            if (!hold) start_i = 1'b0;
            n++;
            @(negedge clk);
            if (ready_o) got = 1;
            else begin
                if (!stallreq_o) stall_bad = 1;
                if (div_by_zero_o) dbz_bad = 1;
                if (busy_o) seen_busy = 1;
            end
        end
        chk("ready_seen", got, 1'b1);
        chk("latency", n, exp_lat);
        chk("stall_until_done", stall_bad, 1'b0);
        chk("dbz_only_with_ready", dbz_bad, 1'b0);
        chk("stall_in_done", stallreq_o, 1'b0);
        if (exp_lat == 1) chk("no_busy_dz", seen_busy, 1'b0);
        x = sb_q.pop_front();
        last = x;
        chk("hi", hi_o, x.hi);
        chk("lo", lo_o, x.lo);
        chk("dbz", div_by_zero_o, x.dbz);
        if (hold) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            chk("hold_no_restart_busy", busy_o, 1'b0);
            chk("hold_no_restart_ready", ready_o, 1'b0);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dbz = dbz;
        return e;
    endfunction

    initial begin
        bit          rdy_bad;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        exp_t        re;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00; opa_i = '0; opb_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_dbz", div_by_zero_o, 1'b0);
        chk("rst_stall", stallreq_o, 1'b0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0), 33, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0), 33, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0000_0000, 1'b0), 33, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 33, 1'b0);
        run_op(2'b11, 32'd7,         32'd2,         mk(32'd1,         32'd3,         1'b0), 33, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0,         32'h8000_0000, 1'b0), 33, 1'b0);
        run_op(2'b11, 32'd100,       32'd0,         mk(32'h64,        32'hFFFF_FFFF, 1'b1),  1, 1'b0);

        // Annul a MULT in cycle 10: no ready pulse, previous results retained.
        @(posedge clk); #1;
        op_i = 2'b00; opa_i = 32'd1234; opb_i = 32'd5678; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 annul_i = 1'b1;
        @(posedge clk); #1 annul_i = 1'b0;
        @(negedge clk);
        chk("annul_busy", busy_o, 1'b0);
        chk("annul_stall", stallreq_o, 1'b0);
        rdy_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rdy_bad = 1;
        end
        chk("annul_no_ready", rdy_bad, 1'b0);
        chk("annul_hi_kept", hi_o, last.hi);
        chk("annul_lo_kept", lo_o, last.lo);
        run_op(2'b11, 32'd9, 32'd3, mk(32'd0, 32'd3, 1'b0), 33, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            if (i % 3 == 0) rb = rb >> $urandom_range(16, 30);
            re  = model(rop, ra, rb);
            run_op(rop, ra, rb, re, (rop[1] && rb == 0) ? 1 : 33, 1'b0);
        end

        run_op(2'b01, 32'd5, 32'd6, mk(32'd0, 32'd30, 1'b0), 33, 1'b1);

        // Reset in cycle 5 of a DIV.
        @(posedge clk); #1;
        op_i = 2'b10; opa_i = 32'd1000; opb_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy_o, 1'b0);
        chk("mrst_ready", ready_o, 1'b0);
        chk("mrst_hi", hi_o, 32'h0);
        chk("mrst_lo", lo_o, 32'h0);
        chk("mrst_dbz", div_by_zero_o, 1'b0);
        chk("mrst_stall", stallreq_o, 1'b0);
        rdy_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rdy_bad = 1;
        end
        chk("mrst_no_ready", rdy_bad, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised iterative multiply/divide unit for the EX stage. It takes signed or unsigned MULT/MULTU/DIV/DIVU operations and computes a 2×WIDTH-bit HI/LO result. It raises a stall request while the operation is in flight and reports completion with a one-cycle ready pulse. It replaces the separate fixed-32-bit mul/div instances, and its HI/LO outputs feed the hi/lo writeback bus.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  request an operation; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- opa_i  in  WIDTH  multiplicand / dividend; latched when start is accepted.
- opb_i  in  WIDTH  multiplier / divisor; latched when start is accepted.
- annul_i  in  1  abort the current or requested operation (flush).
- busy_o  out  1  high in BUSY.
- ready_o  out  1  one-cycle pulse in DONE; hi_o/lo_o are valid from this cycle on.
- hi_o  out  WIDTH  product high half, or remainder for divide.
- lo_o  out  WIDTH  product low half, or quotient for divide.
- div_by_zero_o  out  1  high with ready_o when a DIV/DIVU had opb == 0.
- stallreq_o  out  1  combinational: (IDLE & start_i & ~annul_i) | BUSY.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE → BUSY on start_i & ~annul_i.
  - IDLE → DONE directly for a divide with opb_i == 0.
  - BUSY → DONE when the iteration counter reaches WIDTH.
  - BUSY → IDLE on annul_i.
  - DONE → IDLE unconditionally. start_i is ignored in DONE, because the requesting instruction leaves EX in that cycle.
- On accept:
  - Latch the operation and the magnitudes of opa/opb. Magnitudes are two's-complement absolute values for signed ops and raw values for unsigned ops.
  - Latch the sign flags: negp = sa ^ sb (product/quotient sign), negr = sa (remainder sign).
  - Clear the counter and the accumulators.
- Multiply: radix-2 shift-add over a 2·WIDTH-bit accumulator, one multiplier bit per cycle, WIDTH iterations. The final product is negated if the op is signed and negp is set.
- Divide: restoring division, one quotient bit per cycle, WIDTH iterations.
  - Partial remainder is WIDTH+1 bits so the subtract borrow is detected.
  - Quotient is negated if signed & negp; remainder is negated if signed & negr.
- Divide by zero: lo = all ones, hi = opa_i (raw), div_by_zero_o = 1.
- Signed overflow case, min_int / −1: quotient wraps to min_int and remainder is 0. No flag is raised.
- hi_o/lo_o are registered on the edge that enters DONE and hold until the next DONE. They do not change on annul or in IDLE.
- annul_i:
  - In BUSY: return to IDLE at the next edge with no ready pulse; hi/lo are unchanged.
  - In IDLE: suppresses acceptance of start_i.
- rst: forces IDLE from any state and zeroes the counter and all outputs, including mid-operation.

## Timing
- Reset values: busy_o=0, ready_o=0, hi_o=0, lo_o=0, div_by_zero_o=0; stallreq_o is 0 unless start_i is asserted.
- Start accepted in cycle 0. Iterations run in cycles 1..WIDTH, and ready_o=1 in cycle WIDTH+1, i.e. 33 cycles after the accept cycle at WIDTH=32.
- Divide by zero: ready_o=1 in cycle 1.
- stallreq_o:
  - High from cycle 0 through the last BUSY cycle.
  - Low in the DONE cycle, so the pipeline advances while hi_o/lo_o are valid.
- busy_o: high in cycles 1..WIDTH.
- div_by_zero_o: asserted only together with ready_o, and low otherwise.
- Back-to-back operations: the earliest new accept is the cycle after DONE.

## Test plan
- MULT: opa=0xFFFFFFFD (−3), opb=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; ready_o exactly 33 cycles after the accept cycle; stallreq_o high for 33 cycles.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV: −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100 / 0 → ready_o and div_by_zero_o in cycle 1, lo=0xFFFFFFFF, hi=0x64, busy_o never set.
- annul_i in cycle 10 of a MULT → next cycle IDLE, no ready pulse, hi/lo keep the previous results; a following DIVU 9/3 then gives lo=3, hi=0.
- rst in cycle 5 of a DIV → IDLE with all outputs 0. Also start_i held high through DONE → no second operation starts.
